ysyx_22050550_pending_scoreboard: RTL and testbench
===================================================

# ysyx_22050550_pending_scoreboard

Parametrised register-hazard scoreboard between IDU and the writeback stage(s) of the pipelined core. Per architectural register it keeps a saturating count of outstanding writes instead of a single busy bit, so several in-flight writers to one register and multiple writeback ports are tracked correctly. IDU reads per-source busy flags and a stall request for full counters. A pipeline flush clears all tracking.

## Interface
Parameters:
- NREG, 32: number of architectural registers; register 0 is hard-wired zero and never tracked.
- AW, 5: register address width; NREG <= 2^AW.
- CNTW, 2: per-register counter width; max outstanding writes per register CMAX = 2^CNTW-1.
- NRD, 2: number of IDU source-operand query ports.
- NWB, 2: number of writeback retire ports.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- io_IDU_valid  in  1  IDU holds a valid instruction; gates the busy outputs.
- io_IDU_raddr  in  NRD*AW  packed source addresses; port k is bits [k*AW +: AW].
- io_IDU_busy  out  NRD  bit k = 1 when source k has an outstanding write and io_IDU_valid = 1.
- io_IDU_waddr  in  AW  destination of the issuing instruction.
- io_IDU_wen  in  1  issue fire: the instruction leaves IDU this cycle and will write io_IDU_waddr.
- io_IDU_full  out  1  the counter of io_IDU_waddr equals CMAX; IDU must stall and hold io_IDU_wen low.
- io_WBU_waddr  in  NWB*AW  packed retire addresses.
- io_WBU_wen  in  NWB  bit j = 1 means port j retires one write to its address.
- io_flush  in  1  drop all outstanding writes.
- io_busy_vec  out  NREG  bit r = (cnt[r] != 0), registered view, for debug/difftest.
- io_err  out  1  sticky protocol error flag.

## Operation
- State: cnt[1..NREG-1], each CNTW bits. cnt[0] is constant 0. Plus sticky err.
- Per register r != 0, each cycle:
  - inc = io_IDU_wen & (io_IDU_waddr == r).
  - dec = number of WB ports j with wen[j] & waddr[j] == r. This can be 0..NWB.
  - next = cnt + inc - dec.
- Priority: reset > io_flush > normal update. Flush forces all counters to 0 and ignores same-cycle issue and WB. It does not clear err.
- Overflow: inc with cnt == CMAX and dec == 0 leaves cnt at CMAX and sets err.
- Underflow: if dec > cnt + inc, cnt becomes 0 and err is set.
- Writes to register 0 (issue or WB) are ignored and never set err.
- io_IDU_busy[k] = io_IDU_valid & (cnt[raddr_k] != 0). This is combinational from registered state only, with no bypass of same-cycle WB or issue. A raddr of 0 always reads not busy.
- io_IDU_full = (io_IDU_waddr != 0) & (cnt[io_IDU_waddr] == CMAX). It does not depend on io_IDU_wen.
- err is sticky until reset.

## Timing
- Reset values: all cnt = 0, io_busy_vec = 0, io_err = 0, io_IDU_busy = 0, io_IDU_full = 0.
- Issue at edge t: busy is visible to readers from cycle t+1.
- WB retiring the last write at edge t: busy clears at cycle t+1. A consumer stalled on it advances one cycle after WB.
- Issue and WB to the same register in the same cycle: the count is unchanged. Busy stays asserted if the count was nonzero.
- Flush at edge t: every busy is 0 from cycle t+1. A WB arriving after a flush for a pre-flush write hits cnt 0 and flags err, so upstream must squash stale WB.
- Reset asserted mid-operation: all state returns to the reset values on the next edge, regardless of other inputs.
- No internal pipelining: all outputs are a combinational function of the registered state plus the current addresses and valid.

## Test plan
- Reset then idle: query raddr = 5 with valid = 1 → busy = 0, full = 0, busy_vec = 0, err = 0.
- Issue x5 at cycle 1, then query raddr0 = 5 at cycle 2 → busy[0] = 1. With valid = 0 → busy[0] = 0. WB port0 = x5 at cycle 3 → busy[0] = 0 at cycle 4.
- Issue x7 three times (CMAX = 3) → full = 1 with waddr = 7, err = 0. A fourth issue → cnt stays 3, err = 1. Same cycle as that issue, issue x8 plus WB x7 → cnt[7] = 2 and full drops.
- cnt[9] = 2, then WB ports 0 and 1 both retire x9 in one cycle → busy_vec[9] = 0 next cycle, err = 0. With cnt[9] = 1 and a dual WB → cnt = 0, err = 1.
- Issue x3 and WB x3 in the same cycle with cnt[3] = 1 → cnt stays 1, busy stays 1. Issue and WB to x0 → no change, err = 0.
- Set cnt[4] = 2 and cnt[6] = 1. Assert flush together with issue x10 → busy_vec = 0 next cycle. Reset mid-sequence clears err.

Source files
------------

// File: rtl/ysyx_22050550_pending_scoreboard_if.sv
// Bus bundle between the register-hazard scoreboard and its users.
// The master side is IDU plus the writeback stages and drives issue, retire and flush.
// The slave side is the scoreboard and drives busy, full, busy_vec and err.
//   io_IDU_valid/raddr -> io_IDU_busy : per-source hazard query
//   io_IDU_waddr/wen   -> io_IDU_full : issue fire, and stall when the counter is saturated
//   io_WBU_waddr/wen                  : retire ports
//   io_flush                          : drop all outstanding writes
//   io_busy_vec, io_err               : debug view and sticky protocol error
interface ysyx_22050550_pending_scoreboard_if #(
   parameter int unsigned NREG = 32,
   parameter int unsigned AW   = 5,
   parameter int unsigned NRD  = 2,
   parameter int unsigned NWB  = 2
);
   logic                  io_IDU_valid;
   logic [NRD*AW-1:0]     io_IDU_raddr;
   logic [NRD-1:0]        io_IDU_busy;
   logic [AW-1:0]         io_IDU_waddr;
   logic                  io_IDU_wen;
   logic                  io_IDU_full;
   logic [NWB*AW-1:0]     io_WBU_waddr;
   logic [NWB-1:0]        io_WBU_wen;
   logic                  io_flush;
   logic [NREG-1:0]       io_busy_vec;
   logic                  io_err;

   modport master (
      output io_IDU_valid, io_IDU_raddr, io_IDU_waddr, io_IDU_wen,
             io_WBU_waddr, io_WBU_wen, io_flush,
      input  io_IDU_busy, io_IDU_full, io_busy_vec, io_err
   );

   modport slave (
      input  io_IDU_valid, io_IDU_raddr, io_IDU_waddr, io_IDU_wen,
             io_WBU_waddr, io_WBU_wen, io_flush,
      output io_IDU_busy, io_IDU_full, io_busy_vec, io_err
   );
endinterface

// File: rtl/ysyx_22050550_pending_scoreboard.sv
// Register-hazard scoreboard that keeps a saturating count of outstanding writes for each
// architectural register. Register 0 is never tracked.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high; clears all counters and err
//   bus    scoreboard (slave) side of ysyx_22050550_pending_scoreboard_if
// busy and full are combinational views of the registered counters. Same-cycle issue
// and writeback are not bypassed into them.
module ysyx_22050550_pending_scoreboard #(
   parameter int unsigned NREG = 32,
   parameter int unsigned AW   = 5,
   parameter int unsigned CNTW = 2,
   parameter int unsigned NRD  = 2,
   parameter int unsigned NWB  = 2
) (
   input logic                              clock,
   input logic                              reset,
   ysyx_22050550_pending_scoreboard_if.slave bus
);
   localparam int unsigned CMAX = (1 << CNTW) - 1;
   localparam int unsigned DW   = $clog2(NWB + 1);
   // Wide enough for cnt + inc and for the number of retires, so nothing wraps.
   localparam int unsigned EW   = CNTW + DW + 1;

   logic [CNTW-1:0] cnt_q [NREG];
   logic [CNTW-1:0] cnt_d [NREG];
   logic            err_q;
   logic            err_d;

   // Next counter values: flush wins; otherwise cnt + inc - dec, clamped to the range, and
   // any clamp sets err.
   always_comb begin
      logic [EW-1:0] sum;
      logic [EW-1:0] dec;
      sum   = '0;
      dec   = '0;
      err_d = err_q;
      for (int unsigned r = 0; r < NREG; r++) cnt_d[r] = cnt_q[r];
      cnt_d[0] = '0;
      if (bus.io_flush) begin
         for (int unsigned r = 0; r < NREG; r++) cnt_d[r] = '0;
      end else begin
         for (int unsigned r = 1; r < NREG; r++) begin
            sum = EW'(cnt_q[r]) + EW'(bus.io_IDU_wen && (bus.io_IDU_waddr == AW'(r)));
            dec = '0;
            for (int unsigned j = 0; j < NWB; j++) begin
               if (bus.io_WBU_wen[j] && (bus.io_WBU_waddr[j*AW +: AW] == AW'(r)))
                  dec = dec + EW'(1);
            end
            if (dec > sum) begin
               cnt_d[r] = '0;
               err_d    = 1'b1;
            end else if ((sum - dec) > EW'(CMAX)) begin
               cnt_d[r] = CNTW'(CMAX);
               err_d    = 1'b1;
            end else begin
               cnt_d[r] = CNTW'(sum - dec);
            end
         end
      end
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= '0;
         err_q <= 1'b0;
      end else begin
         for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
         err_q <= err_d;
      end
   end

   // Query outputs taken from registered state only. Out-of-range or zero addresses read
   // as idle.
   always_comb begin
      logic [AW-1:0] ra;
      ra              = '0;
      bus.io_IDU_busy = '0;
      for (int unsigned k = 0; k < NRD; k++) begin
         ra = bus.io_IDU_raddr[k*AW +: AW];
         if (bus.io_IDU_valid && (ra != '0) && (32'(ra) < NREG) && (cnt_q[ra] != '0))
            bus.io_IDU_busy[k] = 1'b1;
      end
      bus.io_IDU_full = (bus.io_IDU_waddr != '0) && (32'(bus.io_IDU_waddr) < NREG) &&
                        (cnt_q[bus.io_IDU_waddr] == CNTW'(CMAX));
      for (int unsigned r = 0; r < NREG; r++) bus.io_busy_vec[r] = (cnt_q[r] != '0);
   end

   assign bus.io_err = err_q;
endmodule

// File: tb/tb_ysyx_22050550_pending_scoreboard.sv
// Bench for the pending-write scoreboard: a directed vector table followed by random
// traffic checked against a counting model.
module tb_ysyx_22050550_pending_scoreboard;
   localparam int unsigned NREG = 32;
   localparam int unsigned AW   = 5;
   localparam int unsigned CNTW = 2;
   localparam int unsigned NRD  = 2;
   localparam int unsigned NWB  = 2;
   localparam int          CMAX = 3;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   ysyx_22050550_pending_scoreboard_if #(.NREG(NREG), .AW(AW), .NRD(NRD), .NWB(NWB)) bus ();

   ysyx_22050550_pending_scoreboard #(
      .NREG(NREG), .AW(AW), .CNTW(CNTW), .NRD(NRD), .NWB(NWB)
   ) u_dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus.slave)
   );

   typedef struct {
      bit          chk;
      bit          rst;
      bit          flush;
      bit          valid;
      int          ra0, ra1;
      bit          wen;
      int          wa;
      int          wbe;
      int          wb0, wb1;
      int          ebusy;
      bit          efull;
      bit          eerr;
      logic [31:0] evec;
   } vec_t;

   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model: plain integer counts per register.
   int   mcnt [NREG];
   bit   merr;

   function automatic logic [31:0] b(int r);
      return 32'(1) << r;
   endfunction

   function automatic vec_t mk(bit chk, bit rst, bit flush, bit valid, int ra0, int ra1,
                               bit wen, int wa, int wbe, int wb0, int wb1,
                               int ebusy, bit efull, bit eerr, logic [31:0] evec);
      vec_t v;
      v.chk = chk; v.rst = rst; v.flush = flush; v.valid = valid; v.ra0 = ra0; v.ra1 = ra1;
      v.wen = wen; v.wa = wa; v.wbe = wbe; v.wb0 = wb0; v.wb1 = wb1;
      v.ebusy = ebusy; v.efull = efull; v.eerr = eerr; v.evec = evec;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(vec_t v);
      reset                = v.rst;
      bus.io_flush         = v.flush;
      bus.io_IDU_valid     = v.valid;
      bus.io_IDU_raddr     = {5'(v.ra1), 5'(v.ra0)};
      bus.io_IDU_wen       = v.wen;
      bus.io_IDU_waddr     = 5'(v.wa);
      bus.io_WBU_wen       = 2'(v.wbe);
      bus.io_WBU_waddr     = {5'(v.wb1), 5'(v.wb0)};
   endtask

   task automatic compare(string tag, vec_t v);
      check({tag, ".busy"},     32'(bus.io_IDU_busy), 32'(v.ebusy));
      check({tag, ".full"},     32'(bus.io_IDU_full), 32'(v.efull));
      check({tag, ".err"},      32'(bus.io_err),      32'(v.eerr));
      check({tag, ".busy_vec"}, bus.io_busy_vec,      v.evec);
   endtask

   // Expected outputs for the current inputs, taken from the model counts.
   function automatic vec_t model_expect(vec_t v);
      vec_t e = v;
      e.ebusy = 0;
      if (v.valid && v.ra0 != 0 && mcnt[v.ra0] != 0) e.ebusy += 1;
      if (v.valid && v.ra1 != 0 && mcnt[v.ra1] != 0) e.ebusy += 2;
      e.efull = (v.wa != 0) && (mcnt[v.wa] == CMAX);
      e.eerr  = merr;
      e.evec  = '0;
      for (int r = 1; r < int'(NREG); r++) if (mcnt[r] != 0) e.evec |= b(r);
      return e;
   endfunction

   // One clock edge of the model: reset, then flush, then count arithmetic with clamping.
   task automatic model_step(vec_t v);
      int n;
      if (v.rst) begin
         foreach (mcnt[r]) mcnt[r] = 0;
         merr = 0;
      end else if (v.flush) begin
         foreach (mcnt[r]) mcnt[r] = 0;
      end else begin
         for (int r = 1; r < int'(NREG); r++) begin
            n = mcnt[r];
            if (v.wen && v.wa == r) n++;
            if (v.wbe[0] && v.wb0 == r) n--;
            if (v.wbe[1] && v.wb1 == r) n--;
            if (n < 0) begin n = 0; merr = 1; end
            if (n > CMAX) begin n = CMAX; merr = 1; end
            mcnt[r] = n;
         end
      end
   endtask

   initial begin
      vec_t v;
      vec_t e;
      foreach (mcnt[r]) mcnt[r] = 0;
      merr = 0;
      //           chk rst fl val ra0 ra1 wen wa wbe wb0 wb1  busy full err vec
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 1, 5, 0, 0, 5, 0, 0, 0,  0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 1, 5, 0, 1, 5, 0, 0, 0,  0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 1, 5, 5, 0, 0, 0, 0, 0,  3, 0, 0, b(5)));
      vecs.push_back(mk(1, 0, 0, 0, 5, 0, 0, 0, 1, 5, 0,  0, 0, 0, b(5)));
      vecs.push_back(mk(1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0,  0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0,  0, 0, 0, b(7)));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0,  0, 0, 0, b(7)));
      vecs.push_back(mk(1, 0, 0, 1, 7, 0, 0, 7, 0, 0, 0,  1, 1, 0, b(7)));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0,  0, 1, 0, b(7)));
      vecs.push_back(mk(1, 0, 0, 1, 7, 8, 1, 8, 1, 7, 0,  1, 0, 1, b(7)));
      vecs.push_back(mk(1, 0, 0, 1, 8, 7, 0, 7, 0, 0, 0,  3, 0, 1, b(7) | b(8)));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 3, 7, 8,  0, 0, 1, b(7) | b(8)));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0,  0, 0, 1, b(7)));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0,  0, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0,  0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0,  0, 0, 0, b(9)));
      vecs.push_back(mk(1, 0, 0, 1, 9, 0, 0, 0, 3, 9, 9,  1, 0, 0, b(9)));
      vecs.push_back(mk(1, 0, 0, 1, 9, 9, 1, 9, 0, 0, 0,  0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 9, 3, 9, 9,  0, 0, 0, b(9)));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0,  0, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 1, 3, 0, 1, 3, 1, 3, 0,  1, 0, 1, b(3)));
      vecs.push_back(mk(1, 0, 0, 1, 3, 0, 1, 0, 3, 0, 0,  1, 0, 1, b(3)));
      vecs.push_back(mk(1, 0, 0, 1, 3, 0, 1, 4, 0, 0, 0,  1, 0, 1, b(3)));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0,  0, 0, 1, b(3) | b(4)));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0,  0, 0, 1, b(3) | b(4)));
      vecs.push_back(mk(1, 0, 1, 1, 4, 6, 1, 10, 1, 3, 0, 3, 0, 1, b(3) | b(4) | b(6)));
      vecs.push_back(mk(1, 0, 0, 1, 4, 6, 0, 10, 0, 0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0,  0, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));

      foreach (vecs[i]) begin
         @(negedge clock);
         drive(vecs[i]);
         #1;
         if (vecs[i].chk) compare($sformatf("vec%0d", i), vecs[i]);
      end

      // Random traffic over a small register window so hazards and clamps are common.
      for (int c = 0; c < 400; c++) begin
         @(negedge clock);
         v = mk(1, ($urandom_range(0, 99) < 3) || (c == 0), $urandom_range(0, 99) < 4,
                1'($urandom_range(0, 1)), $urandom_range(0, 9), $urandom_range(0, 9),
                0, $urandom_range(0, 9), 0, $urandom_range(0, 9), $urandom_range(0, 9),
                0, 0, 0, 0);
         v.wen = ($urandom_range(0, 1) == 1) &&
                 ((mcnt[v.wa] != CMAX) || ($urandom_range(0, 9) == 0));
         v.wbe = ($urandom_range(0, 99) < 40 ? 1 : 0) + ($urandom_range(0, 99) < 40 ? 2 : 0);
         drive(v);
         #1;
         e = model_expect(v);
         compare($sformatf("rnd%0d", c), e);
         model_step(v);
      end

      @(negedge clock);
      reset = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
